// File: rtl/ft64_dcache_ctrl_if.sv
// ft64_dcache_ctrl_if -- system bus seen by the data cache controller.
//   master : controller side (drives cyc_o/stb_o/we_o/sel_o/adr_o/dat_o,
//            receives ack_i/err_i/dat_i)
//   slave  : memory / bus fabric side
interface ft64_dcache_ctrl_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [7:0]  sel_o;
  logic [37:0] adr_o;
  logic [63:0] dat_o;
  logic        ack_i;
  logic        err_i;
  logic [63:0] dat_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  ack_i, err_i, dat_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output ack_i, err_i, dat_i
  );
endinterface

// File: rtl/ft64_dcache_ctrl.sv
// ft64_dcache_ctrl -- sequencer for a direct-mapped, RD_LAT-cycle data cache
// serving one CPU load/store port.
//   clk, rst         : clock, synchronous active-low reset
//   req..dat         : CPU request (latched in IDLE)
//   ack, err, dato   : one-cycle completion pulse, bus error flag, load data
//   dce, c_*         : cache enable, write port (c_wr/c_sel/c_wadr/c_i),
//                      read port (c_radr/c_rdsize -> c_o/c_rhit)
//   bus              : system bus master (line fills, write-through stores)
// Loads that miss fetch the 256-bit line in BEATS beats, write it into the
// cache and replay the lookup. Stores always go to the bus and update the
// cache only if the lookup hit.
module ft64_dcache_ctrl #(
  parameter int RD_LAT = 3,
  parameter int BEATS  = 4,
  parameter int TMO    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [37:0]          adr,
  input  logic [2:0]           size,
  input  logic [7:0]           sel,
  input  logic [63:0]          dat,
  output logic                 ack,
  output logic                 err,
  output logic [63:0]          dato,
  output logic                 dce,
  output logic                 c_wr,
  output logic [31:0]          c_sel,
  output logic [37:0]          c_wadr,
  output logic [255:0]         c_i,
  output logic [2:0]           c_rdsize,
  output logic [37:0]          c_radr,
  input  logic [63:0]          c_o,
  input  logic                 c_rhit,
  ft64_dcache_ctrl_if.master   bus
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL, FILL_WR, ST_BUS, ST_CACHE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [37:0] adr;
    logic [2:0]  size;
    logic [7:0]  sel;
    logic [63:0] dat;
  } req_t;

  state_t                  state, nstate;
  req_t                    rq;
  logic [CW-1:0]           cnt;
  logic [1:0]              beat;   // line is 4 x 64 bits
  logic [TW-1:0]           tmo;
  logic                    hit_r;
  logic [BEATS-1:0][63:0]  line;
  logic                    ack_d, err_d;
  logic [63:0]             dato_d;
  logic                    tmo_hit;

  assign dce      = 1'b1;
  assign c_radr   = rq.adr;
  assign c_rdsize = rq.size;
  // timeout fires on the TMO-th consecutive cycle without ack_i
  assign tmo_hit  = !bus.ack_i && (tmo == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rq    <= '0;
      cnt   <= '0;
      beat  <= '0;
      tmo   <= '0;
      hit_r <= 1'b0;
      line  <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      dato  <= '0;
    end else begin
      state <= nstate;
      ack   <= ack_d;
      err   <= err_d;
      dato  <= dato_d;
      case (state)
        IDLE: if (req) begin
          rq  <= '{we: we, adr: adr, size: size, sel: sel, dat: dat};
          cnt <= CW'(RD_LAT);
        end
        LOOKUP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            hit_r <= c_rhit;
            beat  <= '0;
            tmo   <= '0;
          end
        end
        FILL: begin
          if (bus.ack_i && !bus.err_i) begin
            line[beat] <= bus.dat_i;
            beat       <= beat + 2'd1;
            tmo        <= '0;
          end else if (!bus.ack_i) begin
            tmo <= tmo + TW'(1);
          end
        end
        FILL_WR: cnt <= CW'(RD_LAT);   // replay lookup of the filled line
        ST_BUS: begin
          if (bus.ack_i) tmo <= '0;
          else           tmo <= tmo + TW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nstate     = state;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dato_d     = '0;
    c_wr       = 1'b0;
    c_sel      = '0;
    c_wadr     = rq.adr;
    c_i        = line;
    bus.cyc_o  = 1'b0;
    bus.stb_o  = 1'b0;
    bus.we_o   = 1'b0;
    bus.sel_o  = '0;
    bus.adr_o  = '0;
    bus.dat_o  = '0;
    case (state)
      IDLE: if (req) nstate = LOOKUP;
      LOOKUP: if (cnt == '0) begin
        if (rq.we) nstate = ST_BUS;
        else if (c_rhit) begin
          ack_d  = 1'b1;
          dato_d = c_o;
          nstate = IDLE;
        end else nstate = FILL;
      end
      FILL: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.sel_o = 8'hFF;
        bus.adr_o = {rq.adr[37:5], beat, 3'b000};
        // err_i wins over a simultaneous ack_i
        if (bus.err_i || tmo_hit) begin
          ack_d  = 1'b1;
          err_d  = 1'b1;
          nstate = IDLE;
        end else if (bus.ack_i && beat == 2'(BEATS - 1)) begin
          nstate = FILL_WR;
        end
      end
      FILL_WR: begin
        c_wr   = 1'b1;
        c_sel  = 32'hFFFF_FFFF;
        c_wadr = {rq.adr[37:5], 5'b0};
        nstate = LOOKUP;
      end
      ST_BUS: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.we_o  = 1'b1;
        bus.sel_o = rq.sel;
        bus.adr_o = rq.adr;
        bus.dat_o = rq.dat;
        if (bus.err_i || tmo_hit) begin
          ack_d  = 1'b1;
          err_d  = 1'b1;
          nstate = IDLE;
        end else if (bus.ack_i) begin
          if (hit_r) nstate = ST_CACHE;
          else begin
            ack_d  = 1'b1;
            nstate = IDLE;
          end
        end
      end
      ST_CACHE: begin
        c_wr   = 1'b1;
        c_i    = {4{rq.dat}};
        c_sel  = {24'b0, rq.sel} << {rq.adr[4:3], 3'b000};
        ack_d  = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

endmodule
